img2col_sched: RTL and testbench



---
 rtl/img2col_sched.sv | 165 ++++++++++++++++
 tb/tb_img2col_sched.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/img2col_sched.sv
// Scheduler for one img2col layer pass: fills K-1 window rows, then streams
// tap/PU/round indices to the PU array, with ready/valid stalls on both sides.
module img2col_sched #(
    parameter int NUM_PU     = 28,
    parameter int KSIZE      = 5,
    parameter int NUM_ROUNDS = 28,
    parameter int CW         = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          fill_ready,
    input  logic          map_ready,
    output logic          fill_valid,
    output logic          map_valid,
    output logic [CW-1:0] pu_add,
    output logic [CW-1:0] pu_no,
    output logic [CW-1:0] row_no,
    output logic [CW-1:0] round,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CW-1:0] TAP_LAST   = CW'(KSIZE - 1);
    localparam logic [CW-1:0] PU_LAST    = CW'(NUM_PU - 1);
    localparam logic [CW-1:0] ROW_FILL   = CW'(KSIZE - 2);
    localparam logic [CW-1:0] ROW_RUN    = CW'(KSIZE - 1);
    localparam logic [CW-1:0] ROUND_LAST = CW'(NUM_ROUNDS - 1);

    state_t        state_reg;
    logic [CW-1:0] pu_add_reg;
    logic [CW-1:0] pu_no_reg;
    logic [CW-1:0] row_no_reg;
    logic [CW-1:0] round_reg;
    logic          fill_valid_reg;
    logic          map_valid_reg;
    logic          busy_reg;
    logic          done_reg;

    logic tap_last;
    logic pu_last;
    logic fill_last;
    logic run_last;

    assign tap_last  = (pu_add_reg == TAP_LAST);
    assign pu_last   = (pu_no_reg == PU_LAST);
    assign fill_last = tap_last && pu_last && (row_no_reg == ROW_FILL);
    assign run_last  = tap_last && pu_last && (round_reg == ROUND_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            pu_add_reg     <= '0;
            pu_no_reg      <= '0;
            row_no_reg     <= '0;
            round_reg      <= '0;
            fill_valid_reg <= 1'b0;
            map_valid_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else if (abort && state_reg != IDLE) begin
            // abort beats any beat completing in the same cycle
            state_reg      <= IDLE;
            pu_add_reg     <= '0;
            pu_no_reg      <= '0;
            row_no_reg     <= '0;
            round_reg      <= '0;
            fill_valid_reg <= 1'b0;
            map_valid_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    pu_add_reg <= '0;
                    pu_no_reg  <= '0;
                    row_no_reg <= '0;
                    round_reg  <= '0;
                    done_reg   <= 1'b0;
                    if (start && !abort) begin
                        state_reg      <= FILL;
                        fill_valid_reg <= 1'b1;
                        busy_reg       <= 1'b1;
                    end
                end
                FILL: begin
                    if (fill_ready) begin
                        if (fill_last) begin
                            state_reg      <= RUN;
                            fill_valid_reg <= 1'b0;
                            map_valid_reg  <= 1'b1;
                            pu_add_reg     <= '0;
                            pu_no_reg      <= '0;
                            row_no_reg     <= ROW_RUN;
                            round_reg      <= '0;
                        end else if (tap_last) begin
                            pu_add_reg <= '0;
                            if (pu_last) begin
                                pu_no_reg  <= '0;
                                row_no_reg <= row_no_reg + 1'b1;
                            end else begin
                                pu_no_reg <= pu_no_reg + 1'b1;
                            end
                        end else begin
                            pu_add_reg <= pu_add_reg + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (map_ready) begin
                        if (run_last) begin
                            state_reg     <= DONE;
                            map_valid_reg <= 1'b0;
                            done_reg      <= 1'b1;
                            pu_add_reg    <= '0;
                            pu_no_reg     <= '0;
                            row_no_reg    <= '0;
                            round_reg     <= '0;
                        end else if (tap_last) begin
                            pu_add_reg <= '0;
                            if (pu_last) begin
                                pu_no_reg <= '0;
                                round_reg <= round_reg + 1'b1;
                            end else begin
                                pu_no_reg <= pu_no_reg + 1'b1;
                            end
                        end else begin
                            pu_add_reg <= pu_add_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg      <= IDLE;
                    fill_valid_reg <= 1'b0;
                    map_valid_reg  <= 1'b0;
                    busy_reg       <= 1'b0;
                    done_reg       <= 1'b0;
                end
            endcase
        end
    end

    assign fill_valid = fill_valid_reg;
    assign map_valid  = map_valid_reg;
    assign pu_add     = pu_add_reg;
    assign pu_no      = pu_no_reg;
    assign row_no     = row_no_reg;
    assign round      = round_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_img2col_sched.sv
// Directed bench for img2col_sched: default-size pass plus a 2x2x2 instance
// driven with random readies.
module tb_img2col_sched;

    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, abort = 1'b0, fill_ready = 1'b1, map_ready = 1'b1;
    logic          fill_valid, map_valid, busy, done;
    logic [CW-1:0] pu_add, pu_no, row_no, round;

    logic          s_start = 1'b0, s_abort = 1'b0, s_fill_ready = 1'b0, s_map_ready = 1'b0;
    logic          s_fill_valid, s_map_valid, s_busy, s_done;
    logic [CW-1:0] s_pu_add, s_pu_no, s_row_no, s_round;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    img2col_sched #(.NUM_PU(28), .KSIZE(5), .NUM_ROUNDS(28), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .fill_ready(fill_ready), .map_ready(map_ready),
        .fill_valid(fill_valid), .map_valid(map_valid),
        .pu_add(pu_add), .pu_no(pu_no), .row_no(row_no), .round(round),
        .busy(busy), .done(done)
    );

    img2col_sched #(.NUM_PU(2), .KSIZE(2), .NUM_ROUNDS(2), .CW(CW)) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .abort(s_abort),
        .fill_ready(s_fill_ready), .map_ready(s_map_ready),
        .fill_valid(s_fill_valid), .map_valid(s_map_valid),
        .pu_add(s_pu_add), .pu_no(s_pu_no), .row_no(s_row_no), .round(s_round),
        .busy(s_busy), .done(s_done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fill_first, fill_last, fcount, ferr;
        int map_first, map_last, mcount, merr;
        int dcount, dlast, busy_4481, busy_4482, first_row, first_round;
        int guard, changes, bad;
        logic [CW-1:0] h_pa, h_pn, h_row, h_rd;

        // reset state
        #1;
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_fill_valid", 32'(fill_valid), 0);
        check_val("rst_map_valid", 32'(map_valid), 0);
        check_val("rst_idx", 32'({pu_add, pu_no, row_no, round}), 0);
        tick(); tick();
        rst = 1'b0;

        // idle with start low
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy || fill_valid || map_valid || done) bad++;
        end
        check_val("idle_stays", 32'(bad), 0);

        // full pass, readies high
        fill_first = -1; fill_last = -1; fcount = 0; ferr = 0;
        map_first = -1; map_last = -1; mcount = 0; merr = 0;
        dcount = 0; dlast = -1; busy_4481 = -1; busy_4482 = -1;
        first_row = -1; first_round = -1;
        start = 1'b1;
        for (int n = 1; n <= 4490; n++) begin
            tick();
            start = 1'b0;
            if (fill_valid) begin
                if (fill_first < 0) fill_first = n;
                fill_last = n;
                if (int'(pu_add) != fcount % 5 || int'(pu_no) != (fcount / 5) % 28 ||
                    int'(row_no) != fcount / 140) ferr++;
                fcount++;
            end
            if (map_valid) begin
                if (map_first < 0) begin
                    map_first = n; first_row = int'(row_no); first_round = int'(round);
                end
                map_last = n;
                if (int'(pu_add) != mcount % 5 || int'(pu_no) != (mcount / 5) % 28 ||
                    int'(round) != mcount / 140 || int'(row_no) != 4) merr++;
                mcount++;
            end
            if (done) begin dcount++; dlast = n; end
            if (n == 4481) busy_4481 = int'(busy);
            if (n == 4482) busy_4482 = int'(busy);
        end
        check_val("fill_first", 32'(fill_first), 1);
        check_val("fill_last", 32'(fill_last), 560);
        check_val("fill_beats", 32'(fcount), 560);
        check_val("fill_seq_err", 32'(ferr), 0);
        check_val("map_first", 32'(map_first), 561);
        check_val("map_last", 32'(map_last), 4480);
        check_val("map_beats", 32'(mcount), 3920);
        check_val("map_seq_err", 32'(merr), 0);
        check_val("first_map_row", 32'(first_row), 4);
        check_val("first_map_round", 32'(first_round), 0);
        check_val("done_count", 32'(dcount), 1);
        check_val("done_cycle", 32'(dlast), 4481);
        check_val("busy_at_done", 32'(busy_4481), 1);
        check_val("busy_after_done", 32'(busy_4482), 0);

        // fill stall with map_ready high (ignored in FILL)
        start = 1'b1;
        tick();
        start = 1'b0;
        fill_ready = 1'b0;
        map_ready = 1'b1;
        changes = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (!fill_valid || map_valid || pu_add != 0 || pu_no != 0 || row_no != 0) changes++;
        end
        check_val("fill_stall_frozen", 32'(changes), 0);
        fill_ready = 1'b1;

        // run stall at (4,27,3)
        guard = 0;
        while (!(map_valid && pu_add == 4 && pu_no == 27 && round == 3) && guard < 6000) begin
            tick(); guard++;
        end
        check_val("stall_reached", 32'(guard < 6000), 1);
        h_pa = pu_add; h_pn = pu_no; h_row = row_no; h_rd = round;
        map_ready = 1'b0;
        changes = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (!map_valid || fill_valid || pu_add != h_pa || pu_no != h_pn ||
                row_no != h_row || round != h_rd) changes++;
        end
        check_val("run_stall_frozen", 32'(changes), 0);
        map_ready = 1'b1;
        tick();
        check_val("after_stall_idx", 32'({pu_add, pu_no, row_no, round}),
                  32'({6'd0, 6'd0, 6'd4, 6'd4}));

        // abort at round 10
        guard = 0;
        while (!(map_valid && round == 10) && guard < 6000) begin
            tick(); guard++;
        end
        check_val("abort_reached", 32'(guard < 6000), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_busy", 32'(busy), 0);
        check_val("abort_valids", 32'({fill_valid, map_valid, done}), 0);
        check_val("abort_idx", 32'({pu_add, pu_no, row_no, round}), 0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done || busy) bad++;
        end
        check_val("abort_no_done", 32'(bad), 0);

        // fresh pass refills fully; a start pulse mid-fill is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        fcount = 0; guard = 0;
        while (!map_valid && guard < 2000) begin
            if (fill_valid) fcount++;
            start = (fcount == 100);
            tick(); guard++;
        end
        start = 1'b0;
        check_val("refill_beats", 32'(fcount), 560);
        check_val("refill_run_idx", 32'({pu_add, pu_no, row_no, round}),
                  32'({6'd0, 6'd0, 6'd4, 6'd0}));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_in_run", 32'(busy), 0);

        // start+abort together in IDLE
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check_val("start_abort_idle", 32'({busy, fill_valid}), 0);
        tick();
        check_val("start_abort_idle2", 32'(busy), 0);

        // asynchronous reset mid-fill
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("async_rst_busy", 32'({busy, fill_valid}), 0);
        check_val("async_rst_idx", 32'({pu_add, pu_no, row_no, round}), 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check_val("post_rst_idle", 32'({busy, done}), 0);

        // small instance, random readies
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        fcount = 0; mcount = 0; ferr = 0; merr = 0; dcount = 0; bad = 0;
        for (int i = 0; i < 200; i++) begin
            s_fill_ready = 1'($urandom_range(0, 1));
            s_map_ready  = 1'($urandom_range(0, 1));
            h_pa = s_pu_add; h_pn = s_pu_no; h_row = s_row_no; h_rd = s_round;
            if (s_fill_valid && s_fill_ready) begin
                if (int'(s_pu_add) != fcount % 2 || int'(s_pu_no) != (fcount / 2) % 2 ||
                    s_row_no != 0) ferr++;
                fcount++;
            end
            if (s_map_valid && s_map_ready) begin
                if (int'(s_pu_add) != mcount % 2 || int'(s_pu_no) != (mcount / 2) % 2 ||
                    int'(s_round) != mcount / 4 || s_row_no != 1) merr++;
                mcount++;
            end
            if ((s_fill_valid && !s_fill_ready) || (s_map_valid && !s_map_ready)) begin
                tick();
                if (s_pu_add != h_pa || s_pu_no != h_pn || s_row_no != h_row || s_round != h_rd)
                    bad++;
            end else begin
                tick();
            end
            if (s_done) dcount++;
        end
        check_val("small_fill_beats", 32'(fcount), 4);
        check_val("small_map_beats", 32'(mcount), 8);
        check_val("small_fill_seq", 32'(ferr), 0);
        check_val("small_map_seq", 32'(merr), 0);
        check_val("small_stall_stable", 32'(bad), 0);
        check_val("small_done_pulses", 32'(dcount), 1);
        check_val("small_idle_end", 32'(s_busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
